uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
//   UART receiver that deserialises an asynchronous 8N1 line (ui_in[0] in tt_um_Willow240)
//   into bytes for the core logic. It is the input stage directly upstream of the core.
//   It presents each byte on a valid/ready interface and flags framing and overrun errors.
//   The top level instantiates it with rst = ~rst_n.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per UART bit; even, >= 4
//   DATA_BITS      8  data bits per frame, LSB first; no parity; 1 stop bit
// PORTS
//   clk        in   1          system clock
//   rst        in   1          synchronous, active-high reset
//   rx_in      in   1          asynchronous serial line, idle high
//   rx_data    out  DATA_BITS  received byte; valid only while rx_valid=1
//   rx_valid   out  1          byte available
//   rx_ready   in   1          consumer accepts; transfer when rx_valid & rx_ready
//   frame_err  out  1          1-cycle pulse: stop bit sampled 0, byte discarded
//   overrun    out  1          1-cycle pulse: byte completed while previous one unaccepted
//   busy       out  1          1 whenever FSM != IDLE
// BEHAVIOUR
// - Reset (sync, every clk edge with rst=1):
//   - outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0
//   - internal: sync flops and rx_q = 1; FSM=IDLE; counters = 0
//   - rst mid-frame discards the partial frame.
// - Input path: rx_in passes a 2-flop synchroniser to give rx_s; a third flop gives rx_q.
//   Start detect = rx_s==0 && rx_q==1 (falling edge only).
// - FSM IDLE/START/DATA/STOP; cnt counts clk cycles in the current bit; bit_idx counts data bits.
//   - IDLE: on start detect -> START, cnt=0.
//   - START: when cnt==CLKS_PER_BIT/2-1, sample rx_s.
//     - rx_s=0 -> DATA, cnt=0, bit_idx=0.
//     - rx_s=1 -> IDLE. Glitch: no error, no output.
//   - DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register
//     (LSB-first line order) and reset cnt.
//     After DATA_BITS samples -> STOP.
//   - STOP: when cnt==CLKS_PER_BIT-1, sample rx_s, then -> IDLE.
//     - rx_s=1: byte complete (see output rules).
//     - rx_s=0: frame_err=1 for one cycle; byte dropped; rx_valid/rx_data untouched.
//     - A line held low after a framing error starts no frame until it goes high, then low.
// - Latency: E0 = first clk edge that samples rx_in low.
//   - Stop bit is sampled at edge E0 + 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT.
//   - rx_valid is 1 from that edge onward; that is edge 154 for the defaults.
// - Output rules at byte completion:
//   - rx_valid=0: load rx_data, set rx_valid.
//   - rx_valid=1 and rx_ready=1 this cycle: load the new byte; rx_valid stays 1; no overrun.
//   - rx_valid=1 and rx_ready=0: overrun=1 for one cycle; new byte dropped; old byte kept.
// - Handshake: with no completion, rx_valid & rx_ready clears rx_valid at the next edge.
//   rx_data is stable while rx_valid=1 and not accepted.
// - rx_ready is ignored while rx_valid=0.
// - frame_err and overrun are never asserted in the same cycle.
// TESTING
//   1. rst=1 for 2 cycles, rx_in=1 -> all outputs 0; busy=0 for 20 idle cycles.
//   2. Send 0xA5 at 16 clk/bit, rx_ready=1 -> rx_valid high exactly 1 cycle at E0+154,
//      rx_data=0xA5, frame_err=0.
//   3. Back-to-back 0x3C then 0xC3, rx_ready=0 -> overrun pulses once when 0xC3 completes,
//      rx_data stays 0x3C. Then rx_ready=1 -> rx_valid=0 next cycle.
//   4. Frame 0x55 with stop bit 0, line then held low 40 cycles -> frame_err 1 cycle,
//      no rx_valid, busy=0 while low. Line goes high then sends 0x12 -> 0x12 received.
//   5. rx_in low for 4 cycles only -> busy goes 1 then 0 within CLKS_PER_BIT/2+3 cycles,
//      no rx_valid, no frame_err.
//   6. rst pulse during data bit 3 of 0xFF -> busy=0 after that edge, no rx_valid.
//      A following 0x81 frame is received as 0x81.

Source files
------------

// File: rtl/uart_byte_rx.sv
// uart_byte_rx
//   Receives an asynchronous 8N1 serial line and presents each completed byte
//   on a valid/ready interface. A framing error and an overrun are each flagged
//   with a single-cycle pulse.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   rx_in      in   asynchronous serial line, idle high
//   rx_data    out  received byte, meaningful only while rx_valid=1
//   rx_valid   out  a byte is waiting for the consumer
//   rx_ready   in   consumer accepts; transfer when rx_valid & rx_ready
//   frame_err  out  1-cycle pulse: stop bit sampled low, byte discarded
//   overrun    out  1-cycle pulse: new byte arrived while the previous one was unaccepted
//   busy       out  high whenever the receiver is inside a frame
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    logic sync_1;
    logic rx_s;
    logic rx_q;

    logic start_det;
    logic stop_tick;
    logic byte_done;
    logic frame_bad;

    // Two-flop synchroniser followed by one delay flop. All reset to the idle
    // (high) line level so that leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
            rx_q   <= 1'b1;
        end else begin
            sync_1 <= rx_in;
            rx_s   <= sync_1;
            rx_q   <= rx_s;
        end
    end

    // Only a high-to-low transition starts a frame, so a line stuck low after a
    // framing error cannot retrigger until it has returned high.
    assign start_det = !rx_s && rx_q;

    assign stop_tick = (state == STOP) && (cnt == BIT_LAST);
    assign byte_done = stop_tick && rx_s;
    assign frame_bad = stop_tick && !rx_s;

    assign busy = (state != IDLE);

    // Frame sequencer: the start bit is re-checked at its midpoint, then each
    // following bit is sampled one full bit period later, i.e. mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_det) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A start bit that is already gone by mid-bit was a glitch.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        // Line order is LSB first, so shifting in at the MSB
                        // leaves bit 0 in position 0 after the last data bit.
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output holding register and handshake. A completing byte may replace a
    // held byte only if the held one is being accepted in the same cycle;
    // otherwise the new byte is dropped and overrun pulses. frame_err and
    // overrun come from mutually exclusive stop-bit outcomes, so they never
    // coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx
//   Self-checking bench for uart_byte_rx at 16 clocks per bit. Single frames
//   come from a table of records; back-to-back overrun, framing error with a
//   stuck-low line, start glitch and mid-frame reset are hand-written sequences.
module tb_uart_byte_rx;

    localparam int CPB     = 16;
    localparam int LATENCY = 2 + CPB / 2 + 9 * CPB;   // 154

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    // Monitor totals, only ever written by the monitor process; tests take deltas.
    int   valid_rises = 0;
    int   valid_cycles = 0;
    int   last_rise_cyc = 0;
    logic [7:0] last_rise_data = 8'h00;
    logic prev_valid = 1'b0;
    int   fe_count = 0;
    int   last_fe_cyc = 0;
    int   ov_count = 0;
    int   last_ov_cyc = 0;
    int   busy_cycles = 0;
    int   both_count = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    uart_byte_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Edge number: after posedge N has happened, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    // Sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            valid_rises++;
            last_rise_cyc  = cyc;
            last_rise_data = rx_data;
        end
        if (rx_valid) valid_cycles++;
        prev_valid = rx_valid;
        if (frame_err) begin
            fe_count++;
            last_fe_cyc = cyc;
        end
        if (overrun) begin
            ov_count++;
            last_ov_cyc = cyc;
        end
        if (busy) busy_cycles++;
        if (frame_err && overrun) both_count++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Drives one 8N1 frame, each bit for CPB clock edges; e0 is the first edge
    // that samples the start bit. Returns with the line still at the stop level.
    task automatic sendFrame(input logic [7:0] data, input logic stop_bit, output int e0);
        @(posedge clk);
        #1 rx_in = 1'b0;
        e0 = cyc + 1;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_in = data[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx_in = stop_bit;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int e0;
        int vr0, vc0, fe0;
        vr0 = valid_rises;
        vc0 = valid_cycles;
        fe0 = fe_count;
        sendFrame(v.data, v.stop_bit, e0);
        #1 rx_in = 1'b1;
        repeat (10) @(posedge clk);
        checkOutput($sformatf("vec%0d_valid_rises", idx), valid_rises - vr0, v.exp_valid);
        checkOutput($sformatf("vec%0d_frame_err", idx), fe_count - fe0, v.exp_fe);
        if (v.exp_valid != 0) begin
            checkOutput($sformatf("vec%0d_latency", idx), last_rise_cyc - e0, LATENCY);
            checkOutput($sformatf("vec%0d_data", idx), last_rise_data, v.exp_data);
            checkOutput($sformatf("vec%0d_valid_width", idx), valid_cycles - vc0, 1);
        end
        if (v.exp_fe != 0) begin
            checkOutput($sformatf("vec%0d_fe_time", idx), last_fe_cyc - e0, LATENCY);
        end
    endtask

    initial begin
        int e0a, e0b;
        int vr0, fe0, ov0, b0;

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'h5A, 1'b1, 8'h5A, 1, 0};
        vecs[4] = '{8'h80, 1'b1, 8'h80, 1, 0};
        vecs[5] = '{8'h55, 1'b0, 8'h00, 0, 1};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rx_data", rx_data, 0);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_frame_err", frame_err, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_busy", busy, 0);
        rst = 1'b0;
        b0 = busy_cycles;
        repeat (20) @(posedge clk);
        checkOutput("idle_busy_cycles", busy_cycles - b0, 0);

        // Single frames with the consumer always ready
        rx_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Back-to-back frames with the consumer stalled
        rx_ready = 1'b0;
        vr0 = valid_rises;
        ov0 = ov_count;
        fe0 = fe_count;
        sendFrame(8'h3C, 1'b1, e0a);
        sendFrame(8'hC3, 1'b1, e0b);
        @(negedge clk);
        checkOutput("b2b_valid_rises", valid_rises - vr0, 1);
        checkOutput("b2b_first_latency", last_rise_cyc - e0a, LATENCY);
        checkOutput("b2b_overrun_count", ov_count - ov0, 1);
        checkOutput("b2b_overrun_time", last_ov_cyc - e0b, LATENCY);
        checkOutput("b2b_data_kept", rx_data, 8'h3C);
        checkOutput("b2b_valid_held", rx_valid, 1);
        checkOutput("b2b_frame_err", fe_count - fe0, 0);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_accept_clears", rx_valid, 0);

        // Framing error followed by a stuck-low line, then recovery
        vr0 = valid_rises;
        fe0 = fe_count;
        sendFrame(8'h55, 1'b0, e0a);
        b0 = busy_cycles;
        repeat (40) @(posedge clk);
        checkOutput("ferr_count", fe_count - fe0, 1);
        checkOutput("ferr_time", last_fe_cyc - e0a, LATENCY);
        checkOutput("ferr_no_valid", valid_rises - vr0, 0);
        checkOutput("ferr_busy_while_low", busy_cycles - b0, 0);
        #1 rx_in = 1'b1;
        repeat (20) @(posedge clk);
        vr0 = valid_rises;
        sendFrame(8'h12, 1'b1, e0a);
        #1 rx_in = 1'b1;
        repeat (10) @(posedge clk);
        checkOutput("recover_valid_rises", valid_rises - vr0, 1);
        checkOutput("recover_data", last_rise_data, 8'h12);
        checkOutput("recover_latency", last_rise_cyc - e0a, LATENCY);

        // Start-bit glitch: four low cycles only
        vr0 = valid_rises;
        fe0 = fe_count;
        b0 = busy_cycles;
        @(posedge clk);
        #1 rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        checkOutput("glitch_busy_seen", (busy_cycles - b0) > 0, 1);
        checkOutput("glitch_busy_bounded", (busy_cycles - b0) <= (CPB / 2 + 3), 1);
        checkOutput("glitch_busy_end", busy, 0);
        checkOutput("glitch_no_valid", valid_rises - vr0, 0);
        checkOutput("glitch_no_ferr", fe_count - fe0, 0);

        // Reset in the middle of data bit 3 of 0xFF
        vr0 = valid_rises;
        @(posedge clk);
        #1 rx_in = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (3 * CPB + CPB / 2) @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_busy_before", busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_busy_after", busy, 0);
        checkOutput("midreset_valid_after", rx_valid, 0);
        rst = 1'b0;
        repeat (120) @(posedge clk);
        checkOutput("midreset_no_valid", valid_rises - vr0, 0);
        sendFrame(8'h81, 1'b1, e0a);
        #1 rx_in = 1'b1;
        repeat (10) @(posedge clk);
        checkOutput("after_reset_valid_rises", valid_rises - vr0, 1);
        checkOutput("after_reset_data", last_rise_data, 8'h81);
        checkOutput("after_reset_latency", last_rise_cyc - e0a, LATENCY);

        checkOutput("ferr_overrun_exclusive", both_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
